mcycle_unit: RTL and testbench
==============================

Name: mcycle_unit

Overview:
- Parametrised iterative multiply/divide unit for the Mach-V execute stage; successor to the fixed 32-bit, 8-bit-per-cycle multi-cycle unit.
- Implements the full RV32M operation set, selected by funct3.
- Width and bits-per-cycle are parameters.
- Adds RISC-V divide-by-zero and overflow short-circuit, an abort/flush input, and a Done pulse alongside the Busy stall.

Parameters:
- WIDTH, 32, operand/result width; must be even and >= 8.
- STEP, 8, bits retired per CALC cycle (multiplier slice width and division iterations per cycle); must divide WIDTH.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESETn  in  1  synchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Abort  in  1  pipeline flush; cancels any operation.
- Op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Operand1  in  WIDTH  rs1 (multiplicand/dividend); sampled with Start.
- Operand2  in  WIDTH  rs2 (multiplier/divisor); sampled with Start.
- Result  out  WIDTH  RISC-V result for Op (low product, high product, quotient or remainder).
- Result1  out  WIDTH  product low word / quotient.
- Result2  out  WIDTH  product high word / remainder.
- Busy  out  1  stall request to hazard unit.
- Done  out  1  one-cycle pulse; results valid.

Behaviour:
- Reset (RESETn=0 at edge): state IDLE; Result, Result1, Result2 = 0; Done = 0; internal counter and accumulators cleared. Busy = 0 while RESETn=0. Reset mid-operation discards the operation with no Done.
- States: IDLE, CALC, FIX.
- Define N = WIDTH/STEP.
- IDLE, Start=1, Abort=0:
  - Latch Op, operands, magnitudes and sign flags.
  - Signedness: MULH/DIV/REM treat both operands as signed. MULHSU treats Operand1 as signed, Operand2 as unsigned. MUL, MULHU, DIVU, REMU are unsigned magnitude.
  - Special division case (Op[2]=1 and Operand2=0, or signed DIV/REM with Operand1=2^(WIDTH-1) and Operand2=all-ones) -> FIX. Otherwise -> CALC with counter=0.
- CALC, one slice per cycle:
  - Multiply: acc += |A| * |B|[STEP*k +: STEP] << STEP*k.
  - Divide: STEP restoring shift-subtract iterations on the 2*WIDTH remainder/divisor pair.
  - After N cycles -> FIX.
- FIX:
  - Apply sign correction. Product is negated if the operand signs differ. Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Write Result1/Result2, and select Result: MUL->low; MULH/MULHSU/MULHU->high; DIV/DIVU->quotient; REM/REMU->remainder.
  - Register Done=1 for the next cycle; -> IDLE.
- Special results:
  - Divide by zero: quotient = all-ones, remainder = Operand1.
  - Signed overflow: quotient = Operand1, remainder = 0.
- Latency (cycle 0 = cycle Start is high in IDLE):
  - Normal: Done high in cycle N+2 (6 for defaults).
  - Special: Done high in cycle 2.
- Busy is combinational: 1 when state != IDLE, or when state == IDLE and Start=1 and Abort=0. It is 0 in the Done cycle, so a Start in the Done cycle is accepted.
- Done is high for exactly one cycle. Results hold their values until the next FIX writes them.
- Start while not IDLE is ignored.
- Abort=1 in any state: state -> IDLE at the next edge, no Done, results unchanged. Abort and Start together in IDLE: Abort wins and the request is dropped.
- All arithmetic is modulo 2^WIDTH per word. The accumulator is 2*WIDTH bits wide with no overflow.

Test Plan:
- MULH, Operand1=0xFFFFFFFF, Operand2=0x00000007 -> Result1=0xFFFFFFF9, Result2=0xFFFFFFFF, Result=0xFFFFFFFF, Done in cycle 6, Busy high in cycles 0-5.
- MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> Result1=0x00000001, Result2=Result=0xFFFFFFFE. Also MULHSU, 0xFFFFFFFF x 0xFFFFFFFF -> Result=0xFFFFFFFF.
- DIV, Operand1=0xFFFFFFF9 (-7), Operand2=2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF. Repeat with REM -> Result=0xFFFFFFFF.
- DIVU 100/0 -> Result1=0xFFFFFFFF, Result2=100, Done in cycle 2. DIV 0x80000000 / 0xFFFFFFFF -> Result1=0x80000000, Result2=0, Done in cycle 2.
- Abort asserted in cycle 3 of a MUL -> no Done, Busy=0 from cycle 4. Then Start a MUL 3x5 -> Result=15. RESETn=0 mid-DIV -> all outputs 0, no Done.
- WIDTH=32, STEP=4: DIVU 0xFFFFFFFF/0x10 -> Result1=0x0FFFFFFF, Result2=0xF, Done in cycle 10. Back-to-back Start in the Done cycle is accepted.

Source files
------------

// File: rtl/mcycle_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mcycle_unit
// Purpose  : Iterative RV32M multiply/divide unit. Retires STEP multiplier
//            bits (or STEP restoring-division iterations) per cycle, then
//            applies sign correction in a final FIX cycle.
// Ports    : CLK, RESETn (sync, active-low), Start, Abort, Op (funct3),
//            Operand1/Operand2 (rs1/rs2), Result (Op-selected word),
//            Result1 (low product / quotient), Result2 (high product /
//            remainder), Busy (combinational stall), Done (1-cycle pulse).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mcycle_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic             Abort,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(N - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q;
    logic [CW-1:0]      cnt_q;
    logic               sa_q, sb_q;          // operand negative flags
    logic [2*WIDTH-1:0] a_q;                 // multiplicand, shifted left per slice
    logic [WIDTH-1:0]   b_q;                 // multiplier (shifted right) / divisor
    logic [2*WIDTH-1:0] acc_q;               // product, or {remainder, quotient}
    logic [WIDTH-1:0]   result_q, result1_q, result2_q;
    logic               done_q;

    // ---------------- operand decode (IDLE sampling) ----------------
    logic             w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic             w_div0, w_ovf;

    assign w_sgn_a = (Op == 3'b001) || (Op == 3'b010) || (Op == 3'b100) || (Op == 3'b110);
    assign w_sgn_b = (Op == 3'b001) || (Op == 3'b100) || (Op == 3'b110);
    assign w_neg_a = w_sgn_a & Operand1[WIDTH-1];
    assign w_neg_b = w_sgn_b & Operand2[WIDTH-1];
    assign w_mag_a = w_neg_a ? -Operand1 : Operand1;
    assign w_mag_b = w_neg_b ? -Operand2 : Operand2;
    assign w_div0  = Op[2] & (Operand2 == '0);
    // Among divide ops only DIV/REM are signed, so w_sgn_a & Op[2] selects them.
    assign w_ovf   = Op[2] & w_sgn_a & (Operand1 == MIN_NEG) & (&Operand2);

    // ---------------- per-cycle arithmetic ----------------
    logic [2*WIDTH-1:0] w_partial;
    logic [2*WIDTH-1:0] w_div_acc;
    logic [2*WIDTH:0]   w_div_t;

    assign w_partial = a_q * {{(2*WIDTH-STEP){1'b0}}, b_q[STEP-1:0]};

    // STEP restoring iterations. The shifted upper half is compared at WIDTH+1
    // bits so a divisor with its MSB set never loses the carried-out bit.
    always_comb begin
        w_div_acc = acc_q;
        w_div_t   = '0;
        for (int i = 0; i < STEP; i++) begin
            w_div_t = {w_div_acc, 1'b0};
            if (w_div_t[2*WIDTH:WIDTH] >= {1'b0, b_q}) begin
                w_div_t[2*WIDTH:WIDTH] = w_div_t[2*WIDTH:WIDTH] - {1'b0, b_q};
                w_div_t[0]             = 1'b1;
            end
            w_div_acc = w_div_t[2*WIDTH-1:0];
        end
    end

    // ---------------- sign correction / result selection ----------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot, w_rem, w_lo, w_hi;
    logic               w_sel_lo;

    assign w_prod   = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign w_quot   = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign w_rem    = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign w_lo     = op_q[2] ? w_quot : w_prod[WIDTH-1:0];
    assign w_hi     = op_q[2] ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
    assign w_sel_lo = (op_q == 3'b000) || (op_q[2] && !op_q[1]);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (!RESETn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (Abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (Start) state_d = (w_div0 || w_ovf) ? S_FIX : S_CALC;
                S_CALC:  if (cnt_q == LAST) state_d = S_FIX;
                S_FIX:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        Busy = RESETn & ((state_q != S_IDLE) | (Start & ~Abort));
    end

    // ---------------- datapath ----------------
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            op_q      <= '0;
            cnt_q     <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            result1_q <= '0;
            result2_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!Abort) begin
                case (state_q)
                    S_IDLE: if (Start) begin
                        op_q  <= Op;
                        cnt_q <= '0;
                        sa_q  <= w_neg_a;
                        sb_q  <= w_neg_b;
                        a_q   <= {{WIDTH{1'b0}}, w_mag_a};
                        b_q   <= w_mag_b;
                        // Special cases preload the final {rem, quot} and skip
                        // sign correction by clearing the sign flags.
                        if (w_div0) begin
                            acc_q <= {Operand1, {WIDTH{1'b1}}};
                            sa_q  <= 1'b0;
                            sb_q  <= 1'b0;
                        end else if (w_ovf) begin
                            acc_q <= {{WIDTH{1'b0}}, Operand1};
                            sa_q  <= 1'b0;
                            sb_q  <= 1'b0;
                        end else if (Op[2]) begin
                            acc_q <= {{WIDTH{1'b0}}, w_mag_a};
                        end else begin
                            acc_q <= '0;
                        end
                    end
                    S_CALC: begin
                        cnt_q <= cnt_q + CW'(1);
                        if (op_q[2]) begin
                            acc_q <= w_div_acc;
                        end else begin
                            acc_q <= acc_q + w_partial;
                            a_q   <= a_q << STEP;
                            b_q   <= b_q >> STEP;
                        end
                    end
                    S_FIX: begin
                        result1_q <= w_lo;
                        result2_q <= w_hi;
                        result_q  <= w_sel_lo ? w_lo : w_hi;
                        done_q    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Result  = result_q;
    assign Result1 = result1_q;
    assign Result2 = result2_q;
    assign Done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mcycle_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mcycle_unit
// Purpose  : Self-checking bench for mcycle_unit. Two instances (STEP=8 and
//            STEP=4) share operand/abort/reset stimulus; expected results come
//            from a native-arithmetic model pushed onto a scoreboard at Start
//            and popped at Done.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mcycle_unit;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start8 = 1'b0, start4 = 1'b0, abort = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] opa = '0, opb = '0;
    logic [31:0] res8, r1_8, r2_8, res4, r1_4, r2_4;
    logic        busy8, done8, busy4, done4;
    bit          sel = 1'b0;

    logic [31:0] w_res, w_r1, w_r2;
    logic        w_busy, w_done;
    assign w_res  = sel ? res4  : res8;
    assign w_r1   = sel ? r1_4  : r1_8;
    assign w_r2   = sel ? r2_4  : r2_8;
    assign w_busy = sel ? busy4 : busy8;
    assign w_done = sel ? done4 : done8;

    exp_t sb[$];
    exp_t last;
    int   n_tests = 0;
    int   n_fail  = 0;

    mcycle_unit #(.WIDTH(32), .STEP(8)) dut (
        .CLK(clk), .RESETn(rstn), .Start(start8), .Abort(abort), .Op(op),
        .Operand1(opa), .Operand2(opb), .Result(res8), .Result1(r1_8),
        .Result2(r2_8), .Busy(busy8), .Done(done8)
    );

    mcycle_unit #(.WIDTH(32), .STEP(4)) dut4 (
        .CLK(clk), .RESETn(rstn), .Start(start4), .Abort(abort), .Op(op),
        .Operand1(opa), .Operand2(opb), .Result(res4), .Result1(r1_4),
        .Result2(r2_4), .Busy(busy4), .Done(done4)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Reference model in wide signed arithmetic (SV division truncates toward 0,
    // matching RISC-V).
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input int step);
        exp_t e;
        logic signed [65:0] ea, eb, p, q, r;
        bit s_a, s_b;
        s_a = (o == 3'd1) || (o == 3'd2) || (o == 3'd4) || (o == 3'd6);
        s_b = (o == 3'd1) || (o == 3'd4) || (o == 3'd6);
        ea = {{34{s_a & a[31]}}, a};
        eb = {{34{s_b & b[31]}}, b};
        e.op  = o;
        e.lat = 32 / step + 2;
        if (!o[2]) begin
            p = ea * eb;
            e.r1 = p[31:0];
            e.r2 = p[63:32];
        end else if (b == 32'd0) begin
            e.r1 = 32'hFFFF_FFFF; e.r2 = a; e.lat = 2;
        end else if (s_a && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.r1 = a; e.r2 = 32'd0; e.lat = 2;
        end else begin
            q = ea / eb;
            r = ea % eb;
            e.r1 = q[31:0];
            e.r2 = r[31:0];
        end
        e.res = (o == 3'd0 || o == 3'd4 || o == 3'd5) ? e.r1 : e.r2;
        return e;
    endfunction

    // Drive one Start cycle and push the expectation; returns in cycle 1.
    task automatic go(input bit s, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b);
        sb.push_back(model(o, a, b, s ? 4 : 8));
        sel = s; op = o; opa = a; opb = b;
        if (s) start4 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start4 = 1'b0;
    endtask

    // Wait (bounded) for Done; lat = -1 on timeout. busy_all tracks Busy=1
    // in every cycle before Done.
    task automatic wait_done(output int lat, output bit busy_all);
        int cyc = 1;
        busy_all = 1'b1;
        while (w_done !== 1'b1 && cyc < 64) begin
            if (w_busy !== 1'b1) busy_all = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        lat = (w_done === 1'b1) ? cyc : -1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({res8, r1_8, r2_8} !== 96'd0 || done8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got res=%h r1=%h r2=%h done=%b busy=%b want all 0",
                     res8, r1_8, r2_8, done8, busy8);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [2:0]  ops[4] = '{3'd1, 3'd3, 3'd2, 3'd0};
        logic [31:0] as[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [31:0] bs[4]  = '{32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h9ABC_DEF0};
        int lat; bit bz; exp_t e;
        for (int i = 0; i < 4; i++) begin
            go(1'b0, ops[i], as[i], bs[i]);
            wait_done(lat, bz);
            e = sb.pop_front(); last = e;
            n_tests++;
            if (lat != e.lat) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
            n_tests++;
            if (w_r1 !== e.r1 || w_r2 !== e.r2 || w_res !== e.res) begin
                n_fail++;
                $display("FAIL mul_result[%0d] op=%0d: got r1=%h r2=%h res=%h want r1=%h r2=%h res=%h",
                         i, ops[i], w_r1, w_r2, w_res, e.r1, e.r2, e.res);
            end
            n_tests++;
            if (!bz) begin n_fail++; $display("FAIL mul_busy[%0d]: got Busy low before Done want high", i); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'h8000_0001, 32'd1234};
        int lat; bit bz; exp_t e;
        for (int i = 0; i < 4; i++) begin
            go(1'b0, ops[i], as[i], bs[i]);
            wait_done(lat, bz);
            e = sb.pop_front(); last = e;
            n_tests++;
            if (lat != e.lat) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
            n_tests++;
            if (w_r1 !== e.r1 || w_r2 !== e.r2 || w_res !== e.res) begin
                n_fail++;
                $display("FAIL div_result[%0d] op=%0d: got r1=%h r2=%h res=%h want r1=%h r2=%h res=%h",
                         i, ops[i], w_r1, w_r2, w_res, e.r1, e.r2, e.res);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops[3] = '{3'd5, 3'd4, 3'd6};
        logic [31:0] as[3]  = '{32'd100, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[3]  = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int lat; bit bz; exp_t e;
        for (int i = 0; i < 3; i++) begin
            go(1'b0, ops[i], as[i], bs[i]);
            wait_done(lat, bz);
            e = sb.pop_front(); last = e;
            n_tests++;
            if (lat != 2) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d want 2", i, lat); end
            n_tests++;
            if (w_r1 !== e.r1 || w_r2 !== e.r2 || w_res !== e.res) begin
                n_fail++;
                $display("FAIL special_result[%0d] op=%0d: got r1=%h r2=%h res=%h want r1=%h r2=%h res=%h",
                         i, ops[i], w_r1, w_r2, w_res, e.r1, e.r2, e.res);
            end
        end
    endtask

    task automatic test_abort();
        int lat; bit bz; bit saw_done = 1'b0; exp_t e;
        sel = 1'b0; op = 3'd0; opa = 32'h1111_1111; opb = 32'h2222_2222;
        start8 = 1'b1;                       // cycle 0
        @(posedge clk); #1; start8 = 1'b0;   // cycle 1
        @(posedge clk); #1;                  // cycle 2
        @(posedge clk); #1; abort = 1'b1;    // cycle 3
        @(posedge clk); #1; abort = 1'b0;    // cycle 4
        n_tests++;
        if (w_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", w_busy); end
        for (int i = 0; i < 8; i++) begin
            if (w_done === 1'b1) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (saw_done) begin n_fail++; $display("FAIL abort_done: got Done pulse want none"); end
        n_tests++;
        if (w_r1 !== last.r1 || w_r2 !== last.r2 || w_res !== last.res) begin
            n_fail++;
            $display("FAIL abort_hold: got r1=%h r2=%h res=%h want r1=%h r2=%h res=%h",
                     w_r1, w_r2, w_res, last.r1, last.r2, last.res);
        end
        go(1'b0, 3'd0, 32'd3, 32'd5);
        wait_done(lat, bz);
        e = sb.pop_front(); last = e;
        n_tests++;
        if (lat != 6 || w_res !== 32'd15 || w_res !== e.res) begin
            n_fail++;
            $display("FAIL abort_then_mul: got lat=%0d res=%h want lat=6 res=%h", lat, w_res, 32'd15);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        sel = 1'b0; op = 3'd4; opa = 32'd1000; opb = 32'd7;
        start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        @(posedge clk); #1; rstn = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({res8, r1_8, r2_8} !== 96'd0 || done8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got res=%h r1=%h r2=%h done=%b busy=%b want all 0",
                     res8, r1_8, r2_8, done8, busy8);
        end
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (saw_done) begin n_fail++; $display("FAIL reset_mid_idle: got Done/Busy after reset want none"); end
    endtask

    task automatic test_step4_back_to_back();
        int lat; bit bz; exp_t e;
        go(1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0000_0010);
        wait_done(lat, bz);
        e = sb.pop_front();
        n_tests++;
        if (lat != 10 || w_r1 !== 32'h0FFF_FFFF || w_r2 !== 32'h0000_000F || w_r1 !== e.r1) begin
            n_fail++;
            $display("FAIL step4_divu: got lat=%0d r1=%h r2=%h want lat=10 r1=0fffffff r2=0000000f",
                     lat, w_r1, w_r2);
        end
        // Start issued in the Done cycle must be accepted.
        go(1'b1, 3'd1, 32'h8000_0000, 32'h8000_0000);
        n_tests++;
        if (w_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", w_busy); end
        wait_done(lat, bz);
        e = sb.pop_front();
        n_tests++;
        if (lat != 10 || w_r1 !== e.r1 || w_r2 !== e.r2 || w_res !== e.res) begin
            n_fail++;
            $display("FAIL b2b_mulh: got lat=%0d r1=%h r2=%h res=%h want lat=10 r1=%h r2=%h res=%h",
                     lat, w_r1, w_r2, w_res, e.r1, e.r2, e.res);
        end
    endtask

    task automatic test_random();
        int lat; bit bz; exp_t e;
        logic [2:0] o; logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            go(bit'(i % 2), o, a, b);
            wait_done(lat, bz);
            e = sb.pop_front();
            n_tests++;
            if (lat != e.lat || w_r1 !== e.r1 || w_r2 !== e.r2 || w_res !== e.res) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d r1=%h r2=%h res=%h want lat=%0d r1=%h r2=%h res=%h",
                         i, o, a, b, lat, w_r1, w_r2, w_res, e.lat, e.r1, e.r2, e.res);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_abort();
        test_reset_mid();
        test_step4_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
